// File: rtl/mac_array_acc.sv
// N-lane pipelined multiply-accumulate: per-beat dot product summed across a packet,
// then rounded, optionally ReLU'd and saturated onto a valid/ready output.
module mac_array_acc #(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 3,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_pixel,
    input  logic [LANES*DATA_WIDTH-1:0]   in_weight,
    input  logic                          in_last,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic                          cfg_relu,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_sat
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic adv;

    // S1: registered input beat
    logic                          s1_v_q, s1_last_q, s1_relu_q;
    logic [SHIFT_WIDTH-1:0]        s1_shift_q;
    logic signed [DATA_WIDTH-1:0]  s1_pix_q [LANES];
    logic signed [DATA_WIDTH-1:0]  s1_wgt_q [LANES];

    // S2: per-lane products
    logic                          s2_v_q, s2_last_q, s2_relu_q;
    logic [SHIFT_WIDTH-1:0]        s2_shift_q;
    logic signed [PW-1:0]          s2_prod_d [LANES];
    logic signed [PW-1:0]          s2_prod_q [LANES];

    // S3: lane sum
    logic                          s3_v_q, s3_last_q, s3_relu_q;
    logic [SHIFT_WIDTH-1:0]        s3_shift_q;
    logic signed [ACC_WIDTH-1:0]   s3_sum_d, s3_sum_q;

    // S4: packet accumulator
    logic                          s4_v_q, s4_last_q, s4_relu_q;
    logic [SHIFT_WIDTH-1:0]        s4_shift_q;
    logic signed [ACC_WIDTH-1:0]   acc_d, acc_q;
    logic                          first_q;

    // S5: rounded and shifted packet result
    logic                          s5_v_q, s5_relu_q;
    logic signed [RW-1:0]          s5_r_d, s5_r_q;
    logic [RW-1:0]                 bias;
    logic signed [RW-1:0]          rnd;

    // Output register
    logic                          out_valid_q, out_sat_q, out_sat_d;
    logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic signed [RW-1:0]          clip;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            s2_prod_d[i] = $signed({{DATA_WIDTH{s1_pix_q[i][DATA_WIDTH-1]}}, s1_pix_q[i]})
                         * $signed({{DATA_WIDTH{s1_wgt_q[i][DATA_WIDTH-1]}}, s1_wgt_q[i]});
        end
    end

    always_comb begin
        s3_sum_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            s3_sum_d = s3_sum_d + {{(ACC_WIDTH-PW){s2_prod_q[i][PW-1]}}, s2_prod_q[i]};
        end
    end

    assign acc_d = first_q ? s3_sum_q : acc_q + s3_sum_q;

    // Rounding add is done one bit wider so the half-LSB bias cannot overflow the accumulator.
    always_comb begin
        bias = '0;
        if (s4_shift_q != '0) begin
            bias = {{ACC_WIDTH{1'b0}}, 1'b1} << (s4_shift_q - SHIFT_WIDTH'(1));
        end
        rnd    = {acc_q[ACC_WIDTH-1], acc_q} + bias;
        s5_r_d = rnd >>> s4_shift_q;
        if (int'(s4_shift_q) >= ACC_WIDTH) begin
            s5_r_d = {RW{acc_q[ACC_WIDTH-1]}};
        end
    end

    always_comb begin
        clip = s5_r_q;
        if (s5_relu_q && clip[RW-1]) begin
            clip = '0;
        end
        out_sat_d  = 1'b0;
        out_data_d = clip[OUT_WIDTH-1:0];
        if (clip > OUT_MAX) begin
            out_data_d = OUT_MAX[OUT_WIDTH-1:0];
            out_sat_d  = 1'b1;
        end else if (clip < OUT_MIN) begin
            out_data_d = OUT_MIN[OUT_WIDTH-1:0];
            out_sat_d  = 1'b1;
        end
    end

    // Control and accumulator state: reset, then advance only when the output can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            s4_v_q      <= 1'b0;
            s5_v_q      <= 1'b0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            s1_v_q      <= in_valid;
            s2_v_q      <= s1_v_q;
            s3_v_q      <= s2_v_q;
            s4_v_q      <= s3_v_q;
            s5_v_q      <= s4_v_q && s4_last_q;
            if (s3_v_q) begin
                acc_q   <= acc_d;
                first_q <= s3_last_q;
            end
            out_valid_q <= s5_v_q;
            if (s5_v_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_last_q  <= in_last;
            s1_shift_q <= cfg_shift;
            s1_relu_q  <= cfg_relu;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_pix_q[i] <= in_pixel[i*DATA_WIDTH +: DATA_WIDTH];
                s1_wgt_q[i] <= in_weight[i*DATA_WIDTH +: DATA_WIDTH];
            end

            s2_last_q  <= s1_last_q;
            s2_shift_q <= s1_shift_q;
            s2_relu_q  <= s1_relu_q;
            for (int unsigned i = 0; i < LANES; i++) begin
                s2_prod_q[i] <= s2_prod_d[i];
            end

            s3_last_q  <= s2_last_q;
            s3_shift_q <= s2_shift_q;
            s3_relu_q  <= s2_relu_q;
            s3_sum_q   <= s3_sum_d;

            s4_last_q  <= s3_last_q;
            s4_shift_q <= s3_shift_q;
            s4_relu_q  <= s3_relu_q;

            s5_relu_q  <= s4_relu_q;
            s5_r_q     <= s5_r_d;
        end
    end

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed self-checking bench for mac_array_acc (3 lanes, 16-bit data, 40-bit accumulator).
module tb_mac_array_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_pixel;
    logic [47:0] in_weight;
    logic        in_last;
    logic [5:0]  cfg_shift;
    logic        cfg_relu;
    logic        out_valid;
    logic        out_ready;
    logic signed [15:0] out_data;
    logic        out_sat;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] res_q[$];

    always #5 clk = ~clk;

    mac_array_acc #(
        .DATA_WIDTH (16),
        .LANES      (3),
        .ACC_WIDTH  (40),
        .OUT_WIDTH  (16),
        .SHIFT_WIDTH(6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pixel (in_pixel),
        .in_weight(in_weight),
        .in_last  (in_last),
        .cfg_shift(cfg_shift),
        .cfg_relu (cfg_relu),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    // Handshakes complete at the next rising edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) res_q.push_back({out_sat, out_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input int p0, input int p1, input int p2,
                             input int w0, input int w1, input int w2,
                             input bit last, input int sh, input bit relu);
        int k;
        in_valid  = 1'b1;
        in_pixel  = {16'(p2), 16'(p1), 16'(p0)};
        in_weight = {16'(w2), 16'(w1), 16'(w0)};
        in_last   = last;
        cfg_shift = 6'(sh);
        cfg_relu  = relu;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 100) begin
            n_bad++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(output logic signed [15:0] d, output logic s, output bit got);
        got = 1'b0;
        d   = '0;
        s   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (res_q.size() > 0) break;
            @(posedge clk); #1;
        end
        if (res_q.size() > 0) begin
            {s, d} = res_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic expect_result(input string name, input int exp_d, input bit exp_s);
        logic signed [15:0] d;
        logic s;
        bit got;
        get_result(d, s, got);
        n_cmp++;
        if (!got || d !== 16'(exp_d) || s !== exp_s) begin
            n_bad++;
            $display("FAIL %s: got data %0d sat %0b (arrived %0b), required data %0d sat %0b",
                     name, d, s, got, exp_d, exp_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_pixel = '0; in_weight = '0; cfg_shift = '0; cfg_relu = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b required 0", out_valid); end
        n_cmp++;
        if (out_data !== 16'sd0) begin n_bad++; $display("FAIL reset_data: got %0d required 0", out_data); end
        n_cmp++;
        if (out_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %0b required 0", out_sat); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_basic();
        int cnt;
        send_beat(1, 2, 3, 1, 1, 1, 0, 0, 0);
        send_beat(1, 2, 3, 1, 1, 1, 0, 0, 0);
        send_beat(1, 2, 3, 1, 1, 1, 1, 0, 0);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        n_cmp++;
        if (cnt !== 5) begin n_bad++; $display("FAIL basic_latency: got %0d edges required 5", cnt); end
        expect_result("basic_sum", 18, 0);
    endtask

    task automatic test_rounding();
        send_beat(5, 0, 0, 1, 0, 0, 1, 1, 0);
        expect_result("round_pos", 3, 0);
        send_beat(-5, 0, 0, 1, 0, 0, 1, 1, 0);
        expect_result("round_neg", -2, 0);
        send_beat(-7, 0, 0, 1, 0, 0, 1, 40, 0);
        expect_result("shift_wide_neg", -1, 0);
        send_beat(7, 0, 0, 1, 0, 0, 1, 63, 0);
        expect_result("shift_wide_pos", 0, 0);
    endtask

    task automatic test_saturation();
        send_beat(32767, 32767, 32767, 32767, 32767, 32767, 1, 0, 0);
        expect_result("sat_pos", 32767, 1);
        send_beat(-32768, -32768, -32768, 32767, 32767, 32767, 1, 0, 0);
        expect_result("sat_neg", -32768, 1);
        send_beat(32767, 0, 0, 1, 0, 0, 1, 0, 0);
        expect_result("edge_max", 32767, 0);
        send_beat(-32768, 0, 0, 1, 0, 0, 1, 0, 0);
        expect_result("edge_min", -32768, 0);
    endtask

    task automatic test_relu();
        // relu is taken from the last beat only
        send_beat(-3, 1, 0, 2, 1, 0, 0, 0, 0);
        send_beat(-2, 0, 0, 1, 0, 0, 1, 0, 1);
        expect_result("relu_on", 0, 0);
        send_beat(-3, 1, 0, 2, 1, 0, 0, 0, 1);
        send_beat(-2, 0, 0, 1, 0, 0, 1, 0, 0);
        expect_result("relu_off", -7, 0);
    endtask

    task automatic test_back_to_back();
        send_beat(1, 0, 0, 2, 0, 0, 1, 0, 0);
        send_beat(3, 0, 0, 4, 0, 0, 1, 0, 0);
        send_beat(-5, 0, 0, 6, 0, 0, 1, 0, 0);
        expect_result("b2b_0", 2, 0);
        expect_result("b2b_1", 12, 0);
        expect_result("b2b_2", -30, 0);
    endtask

    task automatic test_backpressure();
        logic signed [15:0] held;
        fork
            begin
                send_beat(1, 1, 0, 1, 1, 0, 0, 0, 0);
                send_beat(2, 0, 0, 3, 0, 0, 1, 0, 0);
                send_beat(0, 0, 4, 0, 0, 5, 0, 0, 0);
                send_beat(1, 1, 1, -1, -1, -1, 1, 0, 0);
            end
            begin
                int k = 0;
                while (!out_valid && k < 40) begin
                    @(posedge clk); #1;
                    k++;
                end
                out_ready = 1'b0;
                held = out_data;
                n_cmp++;
                if (out_valid !== 1'b1 || held !== 16'sd8) begin
                    n_bad++;
                    $display("FAIL bp_first: got valid %0b data %0d required valid 1 data 8", out_valid, held);
                end
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
                        n_bad++;
                        $display("FAIL bp_hold: cycle %0d in_ready %0b valid %0b data %0d required 0 1 %0d",
                                 c, in_ready, out_valid, out_data, held);
                    end
                end
                out_ready = 1'b1;
            end
        join
        expect_result("bp_pkt0", 8, 0);
        expect_result("bp_pkt1", 17, 0);
        repeat (12) @(posedge clk);
        #1;
        n_cmp++;
        if (res_q.size() !== 0) begin
            n_bad++;
            $display("FAIL bp_extra: got %0d extra results required 0", res_q.size());
        end
    endtask

    task automatic test_reset_mid();
        repeat (10) @(posedge clk);
        #1 res_q.delete();
        send_beat(1, 1, 1, 1, 1, 1, 0, 0, 0);
        send_beat(1, 1, 1, 1, 1, 1, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_beat(2, 0, 0, 3, 0, 0, 1, 0, 0);
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (res_q.size() !== 1) begin
            n_bad++;
            $display("FAIL rstmid_count: got %0d results required 1", res_q.size());
        end
        expect_result("rstmid_value", 6, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_relu();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
